inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction fetch stage; sits directly upstream of the decode stage.
- Holds the PC and issues single-outstanding read requests to instruction memory.
- Buffers returned 32-bit instruction words in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts PC redirects from the condition/branch unit, flushing buffered and in-flight fetches.

Parameters:
- PC_W, 32, PC and address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment per instruction.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- imem_req  out  1  read request; held high until imem_ack.
- imem_addr  out  PC_W  read address; stable while imem_req is high.
- imem_ack  in  1  one-cycle pulse: imem_rdata valid.
- imem_rdata  in  32  instruction word.
- redirect_en  in  1  one-cycle pulse: load redirect_pc, flush.
- redirect_pc  in  PC_W  new fetch address; low 2 bits ignored (forced 0).
- inst_valid  out  1  inst_out/inst_pc hold a valid instruction.
- inst_ready  in  1  decode accepts this cycle.
- inst_out  out  32  instruction word; feeds decode's opcode input.
- inst_pc  out  PC_W  address of inst_out.

Behaviour:
- Reset (async, asserted at any time, including mid-request): pc=RESET_PC, state=IDLE, FIFO empty, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_out=0, inst_pc=0. An imem_ack arriving after reset deasserts is ignored unless the block is in WAIT.
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, response will be kept.
  - DROP: request outstanding, response will be discarded.
- imem_req=1 in WAIT and DROP. imem_addr is registered at issue and is stable for the whole request.
- IDLE→WAIT when (fifo_count + 0) < FIFO_DEPTH and redirect_en=0; imem_addr<=pc at issue. The first request after reset issues in cycle 1, so imem_req is high in the cycle after rst deasserts.
- WAIT, imem_ack=1, redirect_en=0: push {imem_rdata, imem_addr} into the FIFO, pc<=pc+PC_STEP, →IDLE. The next issue earns no extra bubble in this design: minimum throughput is one instruction per 2 cycles.
- WAIT, redirect_en=0, imem_ack=0: stay.
- WAIT, redirect_en=1: if imem_ack=1 the same cycle, discard the data and →IDLE; otherwise →DROP.
- DROP, imem_ack=1: discard the data, →IDLE.
- DROP, redirect_en=1: stay in DROP (or →IDLE if imem_ack is the same cycle); the latest redirect_pc wins.
- Redirect (any state): pc<=redirect_pc&~3, FIFO flushed next cycle, inst_valid=0 the cycle after. No issue occurs in the redirect cycle.
- Output handshake:
  - inst_valid = FIFO non-empty; inst_out/inst_pc = FIFO head.
  - A pop occurs when inst_valid&&inst_ready.
  - If a pop coincides with redirect_en, the pop counts as consumed and the remaining entries are flushed.
  - Head data must not change while inst_valid=1 && inst_ready=0.
- FIFO full: no new issue; an outstanding request may still complete because issue requires space before it happens.
- Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- PC arithmetic wraps modulo 2^PC_W (e.g. 32'hFFFF_FFFC + 4 → 0).

Decomposition:
- Shared package (sg32_pkg):
  - fetch state enum {IDLE, WAIT, DROP}
  - PC_STEP
  - INST_W=32
  - RESET_PC default
- Sub-module inst_fifo: parameterised depth/width synchronous FIFO with push, pop, flush, count, full and empty, and async active-high reset. It holds {pc, inst} pairs.

Test Plan:
- Reset then sequential fetch, 1-cycle memory latency, inst_ready=1 → imem_addr 0,4,8,…; inst_out equals the memory words in order with inst_pc matching; no loss or duplication over 16 instructions.
- inst_ready=0 for 10 cycles → FIFO fills to 2, imem_req stays low while full, inst_out/inst_pc stable. Release → entries drain in order, then fetch resumes at pc 8.
- redirect_en with redirect_pc=32'h100 while in WAIT, ack 3 cycles later → old data dropped, next imem_addr=0x100, first inst_pc=0x100.
- redirect_en in the same cycle as imem_ack → that ack's data is never presented; next request to the redirect target.
- Redirect in the same cycle as a pop with 2 entries buffered → head consumed once, the second entry never appears, inst_valid=0 next cycle.
- rst pulsed asynchronously mid-WAIT → all outputs return to reset values immediately; after release, fetch restarts at RESET_PC; a stale ack during reset is ignored.

Source files
------------

// File: rtl/sg32_pkg.sv
// rtl/sg32_pkg.sv - shared fetch-stage types and constants
package sg32_pkg;

  // Fetch request tracking: no request, request whose data is kept, request whose data is discarded
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam int          INST_W       = 32;
  localparam int          PC_STEP_DEF  = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/inst_fifo.sv
// rtl/inst_fifo.sv - small synchronous FIFO holding {pc, inst} pairs
module inst_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees its slot in the same cycle, so push-while-full is accepted alongside a pop
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage, pointers and occupancy; flush discards everything including a same-cycle pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage with single-outstanding memory reads
module inst_fetch
  import sg32_pkg::*;
#(
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(RESET_PC_DEF),
  parameter int              PC_STEP    = PC_STEP_DEF,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_en,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [PC_W-1:0]   inst_pc
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = PC_W + INST_W;

  fetch_state_e     state_q;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  addr_q;
  logic             req_q;

  logic [PC_W-1:0]  redirect_target_d;
  logic [PC_W-1:0]  pc_seq_d;
  logic             space_d;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [ENT_W-1:0] fifo_head;

  assign redirect_target_d = {redirect_pc[PC_W-1:2], 2'b00};
  assign pc_seq_d          = pc_q + PC_W'(PC_STEP);

  // Space is judged on current occupancy only: a same-cycle pop does not enable an issue
  assign space_d = (fifo_count < CNT_W'(FIFO_DEPTH));

  // Only kept responses are buffered; a response meeting a redirect is discarded
  assign fifo_push = (state_q == WAIT) && imem_ack && !redirect_en && (!fifo_full || fifo_pop);
  assign fifo_pop  = inst_valid && inst_ready;

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst_valid = !fifo_empty;
  assign inst_pc    = fifo_head[ENT_W-1 -: PC_W];
  assign inst_out   = fifo_head[INST_W-1:0];

  inst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (redirect_en),
    .wdata_i ({addr_q, imem_rdata}),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Request FSM with PC tracking; request and address are registered so they hold steady until ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      if (redirect_en) begin
        pc_q <= redirect_target_d;
      end else if (fifo_push) begin
        pc_q <= pc_seq_d;
      end
      case (state_q)
        IDLE: begin
          if (!redirect_en && space_d) begin
            state_q <= WAIT;
            req_q   <= 1'b1;
            addr_q  <= pc_q;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end else if (redirect_en) begin
            state_q <= DROP;
          end
        end
        DROP: begin
          if (imem_ack) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  inst_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_addr;
    logic        exp_valid_after;
  } redir_vec_t;

  exp_t       sb[$];
  redir_vec_t vecs[4];

  int errors    = 0;
  int checks    = 0;
  int delivered = 0;
  int base;
  bit mem_auto  = 1'b0;
  int mem_lat   = 0;
  int wait_cnt  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = mem_word(pc);
    sb.push_back(e);
  endtask

  // One clock: memory model reacts, consumer pops are scored, then advance to 2 time units past the edge
  task automatic tick();
    exp_t e;
    if (mem_auto) begin
      if (imem_req && wait_cnt >= mem_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        wait_cnt   = 0;
      end else begin
        imem_ack = 1'b0;
        if (imem_req) wait_cnt++;
      end
    end
    if (inst_valid && inst_ready) begin
      delivered++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got pc %h with nothing expected", inst_pc);
      end else begin
        e = sb.pop_front();
        check("pop_pc", inst_pc, e.pc);
        check("pop_inst", inst_out, e.inst);
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic run_until(input string name, input int target, input int budget);
    for (int g = 0; g < budget && delivered < target; g++) tick();
    check(name, delivered, target);
  endtask

  initial begin
    vecs[0] = '{target: 32'h0000_0100, exp_addr: 32'h0000_0100, exp_valid_after: 1'b0};
    vecs[1] = '{target: 32'h0000_0203, exp_addr: 32'h0000_0200, exp_valid_after: 1'b0};
    vecs[2] = '{target: 32'h0000_1FFF, exp_addr: 32'h0000_1FFC, exp_valid_after: 1'b0};
    vecs[3] = '{target: 32'hFFFF_FFFE, exp_addr: 32'hFFFF_FFFC, exp_valid_after: 1'b0};

    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    redirect_en = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", inst_valid, 0);
    check("rst_inst_out", inst_out, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);

    // Sequential fetch, one wait cycle per request, consumer always ready
    rst = 1'b0;
    mem_auto = 1'b1; mem_lat = 1; wait_cnt = 0;
    tick();
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 32'h0);
    for (int i = 0; i < 16; i++) expect_pc(32'(i * 4));
    inst_ready = 1'b1;
    run_until("seq16_delivered", 16, 300);
    inst_ready = 1'b0;
    check("seq16_sb_empty", sb.size(), 0);

    // Async reset in the middle of an outstanding request with an entry buffered
    mem_auto = 1'b0; imem_ack = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    sb.delete();
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h1111_0000; tick(); imem_ack = 1'b0;
    tick();
    check("pre_rst_valid", inst_valid, 1);
    check("pre_rst_addr", imem_addr, 32'h4);
    #3; rst = 1'b1; #1;
    check("async_rst_req", imem_req, 0);
    check("async_rst_addr", imem_addr, 32'h0);
    check("async_rst_valid", inst_valid, 0);
    check("async_rst_inst_out", inst_out, 32'h0);
    check("async_rst_inst_pc", inst_pc, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #2;
    check("rst_held_req", imem_req, 0);
    rst = 1'b0;
    tick();
    imem_ack = 1'b0;
    check("post_rst_req", imem_req, 1);
    check("post_rst_addr", imem_addr, 32'h0);
    check("stale_ack_ignored", inst_valid, 0);

    // Stall: buffer fills to two, requests stop, head holds; then drain and resume at pc 8
    mem_auto = 1'b1; mem_lat = 1; wait_cnt = 0;
    sb.delete();
    for (int i = 0; i < 4; i++) expect_pc(32'(i * 4));
    base = delivered;
    repeat (10) tick();
    check("stall_valid", inst_valid, 1);
    check("stall_head_pc", inst_pc, 32'h0);
    check("stall_head_inst", inst_out, mem_word(32'h0));
    check("stall_no_req", imem_req, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_req_low", imem_req, 0);
      check("stall_pc_stable", inst_pc, 32'h0);
    end
    inst_ready = 1'b1;
    tick();
    check("no_issue_on_pop_cycle", imem_req, 0);
    tick();
    check("resume_req", imem_req, 1);
    check("resume_addr", imem_addr, 32'h8);
    run_until("stall_drain_delivered", base + 4, 100);
    inst_ready = 1'b0;
    check("stall_sb_empty", sb.size(), 0);

    // Table of redirect targets: low bits masked, wrap of the PC past the top of memory
    mem_lat = 0;
    for (int v = 0; v < 4; v++) begin
      repeat (10) tick();
      redirect_en = 1'b1; redirect_pc = vecs[v].target;
      tick();
      redirect_en = 1'b0;
      sb.delete();
      check("redir_valid_after", inst_valid, vecs[v].exp_valid_after);
      tick();
      check("redir_req", imem_req, 1);
      check("redir_addr", imem_addr, vecs[v].exp_addr);
      for (int i = 0; i < 3; i++) expect_pc(vecs[v].exp_addr + 32'(i * 4));
      base = delivered;
      inst_ready = 1'b1;
      run_until("redir_delivered", base + 3, 60);
      inst_ready = 1'b0;
    end
    repeat (10) tick();

    // Redirect while waiting, ack arrives three cycles later and is dropped
    mem_auto = 1'b0; imem_ack = 1'b0;
    redirect_en = 1'b1; redirect_pc = 32'h40; tick(); redirect_en = 1'b0;
    sb.delete();
    tick();
    check("a_req_40", imem_addr, 32'h40);
    redirect_en = 1'b1; redirect_pc = 32'h100; tick(); redirect_en = 1'b0;
    check("a_drop_req_held", imem_req, 1);
    check("a_drop_addr_held", imem_addr, 32'h40);
    tick(); tick();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; tick(); imem_ack = 1'b0;
    check("a_drop_req_done", imem_req, 0);
    check("a_drop_no_valid", inst_valid, 0);
    tick();
    check("a_new_req", imem_req, 1);
    check("a_new_addr", imem_addr, 32'h100);
    expect_pc(32'h100);
    base = delivered;
    imem_ack = 1'b1; imem_rdata = mem_word(32'h100); tick(); imem_ack = 1'b0;
    inst_ready = 1'b1; tick(); inst_ready = 1'b0;
    check("a_delivered", delivered, base + 1);
    check("a_next_addr", imem_addr, 32'h104);

    // Redirect in the same cycle as an ack: that data is never presented
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0001;
    redirect_en = 1'b1; redirect_pc = 32'h200;
    tick();
    imem_ack = 1'b0; redirect_en = 1'b0;
    check("b_req_low", imem_req, 0);
    check("b_no_valid", inst_valid, 0);
    tick();
    check("b_new_addr", imem_addr, 32'h200);
    expect_pc(32'h200);
    base = delivered;
    imem_ack = 1'b1; imem_rdata = mem_word(32'h200); tick(); imem_ack = 1'b0;
    inst_ready = 1'b1; tick(); inst_ready = 1'b0;
    check("b_delivered", delivered, base + 1);

    // Redirect coinciding with a pop while two entries are buffered
    mem_auto = 1'b1; mem_lat = 0; wait_cnt = 0;
    sb.delete();
    expect_pc(32'h204);
    expect_pc(32'h208);
    repeat (8) tick();
    check("c_full_head", inst_pc, 32'h204);
    check("c_full_no_req", imem_req, 0);
    base = delivered;
    inst_ready = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h300;
    tick();
    inst_ready = 1'b0; redirect_en = 1'b0;
    check("c_flushed_valid", inst_valid, 0);
    check("c_head_consumed_once", delivered, base + 1);
    sb.delete();
    expect_pc(32'h300);
    expect_pc(32'h304);
    inst_ready = 1'b1;
    run_until("c_after_redirect", base + 3, 60);
    inst_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
